// File: rtl/cpu_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : cpu_boot_loader
// Purpose  : Boot sequencer in front of the CPU. Streams 32-bit program words
//            into instruction memory from word address 0 over a valid/ready
//            handshake, holds the CPU in reset while loading, then releases it
//            to run from a latched start PC.
// Ports    : clk, reset (async, active high)
//            load_start, boot_pc            - session request / start PC
//            load_valid, load_ready,
//            load_data, load_last           - program word stream
//            imem_we, imem_addr, imem_wdata - instruction-memory write port
//            cpu_reset, cpu_goe, cpu_pcdata - CPU boot controls
//            busy, word_count, overflow     - status
// Revision : 1.0 - initial release
// ============================================================================
module cpu_boot_loader #(
    parameter int ADDR_WIDTH  = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic [31:0]           boot_pc,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [31:0]           load_data,
    input  logic                  load_last,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_reset,
    output logic                  cpu_goe,
    output logic [31:0]           cpu_pcdata,
    output logic                  busy,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  overflow
);

    localparam logic [1:0] C_ST_HALT = 2'd0;
    localparam logic [1:0] C_ST_LOAD = 2'd1;
    localparam logic [1:0] C_ST_HOLD = 2'd2;
    localparam logic [1:0] C_ST_RUN  = 2'd3;

    localparam int C_HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [C_HOLD_W-1:0] C_HOLD_LAST = C_HOLD_W'(HOLD_CYCLES - 1);
    // Count value at which one more accepted word fills the memory.
    localparam logic [ADDR_WIDTH:0] C_FINAL_SLOT = {1'b0, {ADDR_WIDTH{1'b1}}};

    logic [1:0]            state_q,      state_d;
    logic [C_HOLD_W-1:0]   hold_cnt_q,   hold_cnt_d;
    logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
    logic                  overflow_q,   overflow_d;
    logic [31:0]           boot_pc_q,    boot_pc_d;
    logic [31:0]           cpu_pcdata_q, cpu_pcdata_d;
    logic                  imem_we_q,    imem_we_d;
    logic [ADDR_WIDTH-1:0] imem_addr_q,  imem_addr_d;
    logic [31:0]           imem_wdata_q, imem_wdata_d;
    logic                  cpu_reset_q,  cpu_reset_d;
    logic                  cpu_goe_q,    cpu_goe_d;
    logic                  busy_q,       busy_d;

    logic w_accept;
    logic w_start;

    assign load_ready = (state_q == C_ST_LOAD);
    assign w_accept   = load_ready & load_valid;
    assign w_start    = load_start & ((state_q == C_ST_HALT) | (state_q == C_ST_RUN));

    // ------------------------------------------------------------------
    // State register (plus all registered outputs and datapath)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= C_ST_HALT;
            hold_cnt_q   <= '0;
            word_count_q <= '0;
            overflow_q   <= 1'b0;
            boot_pc_q    <= '0;
            cpu_pcdata_q <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_reset_q  <= 1'b1;
            cpu_goe_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            word_count_q <= word_count_d;
            overflow_q   <= overflow_d;
            boot_pc_q    <= boot_pc_d;
            cpu_pcdata_q <= cpu_pcdata_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_reset_q  <= cpu_reset_d;
            cpu_goe_q    <= cpu_goe_d;
            busy_q       <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            C_ST_HALT: begin
                if (load_start) state_d = C_ST_LOAD;
            end
            C_ST_LOAD: begin
                // Session ends on the tagged last word or when memory is full.
                if (w_accept && (load_last || (word_count_q == C_FINAL_SLOT))) begin
                    state_d    = C_ST_HOLD;
                    hold_cnt_d = '0;
                end
            end
            C_ST_HOLD: begin
                if (hold_cnt_q == C_HOLD_LAST) begin
                    state_d = C_ST_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + C_HOLD_W'(1);
                end
            end
            C_ST_RUN: begin
                if (load_start) state_d = C_ST_LOAD;
            end
            default: state_d = C_ST_HALT;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath logic. CPU controls are derived from the next
    // state so they change on the same edge as the state itself.
    // ------------------------------------------------------------------
    always_comb begin
        word_count_d = word_count_q;
        overflow_d   = overflow_q;
        boot_pc_d    = boot_pc_q;
        cpu_pcdata_d = cpu_pcdata_q;
        imem_we_d    = w_accept;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;

        if (w_accept) begin
            imem_addr_d  = word_count_q[ADDR_WIDTH-1:0];
            imem_wdata_d = load_data;
            word_count_d = word_count_q + (ADDR_WIDTH+1)'(1);
            overflow_d   = (word_count_q == C_FINAL_SLOT) && !load_last;
        end

        if (w_start) begin
            boot_pc_d    = boot_pc;
            word_count_d = '0;
            overflow_d   = 1'b0;
        end

        // Present the latched PC as HOLD is entered; it then stays put.
        if ((state_q == C_ST_LOAD) && (state_d == C_ST_HOLD)) begin
            cpu_pcdata_d = boot_pc_q;
        end

        cpu_reset_d = (state_d != C_ST_RUN);
        cpu_goe_d   = (state_d == C_ST_HOLD) || (state_d == C_ST_RUN);
        busy_d      = (state_d == C_ST_LOAD) || (state_d == C_ST_HOLD);
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_reset  = cpu_reset_q;
    assign cpu_goe    = cpu_goe_q;
    assign cpu_pcdata = cpu_pcdata_q;
    assign busy       = busy_q;
    assign word_count = word_count_q;
    assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_boot_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_cpu_boot_loader
// Purpose  : Self-checking bench for cpu_boot_loader (4-word memory, 4 hold
//            cycles). Sessions are driven from a directed + random sequence;
//            expected writes, counts, flags and release timing come from the
//            program description of each session.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_boot_loader;

    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;
    localparam int HOLD  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load_start = 1'b0;
    logic [31:0]   boot_pc = '0;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic [31:0]   load_data = '0;
    logic          load_last = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_reset;
    logic          cpu_goe;
    logic [31:0]   cpu_pcdata;
    logic          busy;
    logic [AW:0]   word_count;
    logic          overflow;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    logic [31:0] prog [8];

    always #5 clk = ~clk;

    cpu_boot_loader #(.ADDR_WIDTH(AW), .HOLD_CYCLES(HOLD)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .boot_pc    (boot_pc),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_last  (load_last),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .cpu_goe    (cpu_goe),
        .cpu_pcdata (cpu_pcdata),
        .busy       (busy),
        .word_count (word_count),
        .overflow   (overflow)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One load session: n words from prog[], tagged last on word n-1 when
    // use_last. mode 0 = valid every cycle, 1 = every other cycle, 2 = random
    // (also throws in ignored load_start pulses while loading).
    task automatic do_session(input logic [31:0] pc, input int n, input bit use_last,
                              input int mode);
        int  k_exp;
        bit  ovf_exp;
        int  idx;
        int  cyc;
        bit  acc;
        bit  rdy;
        bit  done;
        k_exp   = (use_last && n <= DEPTH) ? n : DEPTH;
        ovf_exp = !(use_last && n <= DEPTH);

        @(negedge clk);
        load_start = 1'b1;
        boot_pc    = pc;
        @(negedge clk);
        load_start = 1'b0;
        boot_pc    = $urandom;          // must have been latched already
        check("start_cpu_reset", cpu_reset, 1);
        check("start_ready", load_ready, 1);
        check("start_busy", busy, 1);
        check("start_word_count", word_count, 0);
        check("start_overflow", overflow, 0);

        idx  = 0;
        acc  = 1'b0;
        done = 1'b0;
        cyc  = 0;
        while (!done && cyc < 4 * n + 8) begin
            if (acc) begin
                check("wr_we", imem_we, 1);
                check("wr_addr", imem_addr, idx - 1);
                check("wr_data", imem_wdata, prog[idx-1]);
                check("wr_count", word_count, idx);
            end else if (cyc > 0) begin
                check("no_wr", imem_we, 0);
            end
            if (acc && idx == k_exp) begin
                done = 1'b1;
            end else begin
                load_valid = (idx < n) && (mode == 0 || (mode == 1 && cyc % 2 == 0) ||
                                           (mode == 2 && $urandom_range(0, 1) == 1));
                load_data  = load_valid ? prog[idx] : $urandom;
                load_last  = use_last && (idx == n - 1);
                load_start = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
                rdy = load_ready;
                @(posedge clk);
                acc = load_valid && rdy;
                if (acc) idx++;
                @(negedge clk);
                cyc++;
            end
        end
        if (!done) begin
            fails++;
            checks++;
            $error("FAIL session_timeout: observed=%0d words expected=%0d", idx, k_exp);
        end

        // First HOLD cycle; keep offering surplus words, none may be taken.
        load_start = 1'b0;
        load_last  = 1'b0;
        load_valid = (idx < n);
        load_data  = prog[idx];
        check("hold_cpu_reset", cpu_reset, 1);
        check("hold_goe", cpu_goe, 1);
        check("hold_busy", busy, 1);
        check("hold_ready", load_ready, 0);
        check("hold_pc", cpu_pcdata, pc);
        check("hold_count", word_count, k_exp);
        check("hold_overflow", overflow, ovf_exp);
        for (int j = 2; j <= HOLD; j++) begin
            load_start = (j == 2);      // ignored while in HOLD
            @(negedge clk);
            check("hold_reset_kept", cpu_reset, 1);
            check("hold_goe_kept", cpu_goe, 1);
            check("hold_no_wr", imem_we, 0);
        end
        load_start = 1'b0;
        @(negedge clk);
        load_valid = 1'b0;
        check("run_cpu_reset", cpu_reset, 0);
        check("run_goe", cpu_goe, 1);
        check("run_busy", busy, 0);
        check("run_pc", cpu_pcdata, pc);
        check("run_count", word_count, k_exp);
        check("run_overflow", overflow, ovf_exp);
        check("run_no_wr", imem_we, 0);
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_goe", cpu_goe, 0);
        check("rst_pc", cpu_pcdata, 0);
        check("rst_we", imem_we, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_wdata", imem_wdata, 0);
        check("rst_count", word_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", load_ready, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("halt_cpu_reset", cpu_reset, 1);
        check("halt_goe", cpu_goe, 0);
        check("halt_ready", load_ready, 0);
        check("halt_busy", busy, 0);

        // Three-word load
        prog[0] = 32'h2001_0005;
        prog[1] = 32'h2002_0003;
        prog[2] = 32'h0022_1820;
        do_session(32'h0000_0040, 3, 1'b1, 0);

        // Handshake stalls (reload from RUN)
        for (int i = 0; i < 8; i++) prog[i] = $urandom;
        do_session(32'h1234_5678, 4, 1'b1, 1);

        // Overflow: 6 words, no last
        for (int i = 0; i < 8; i++) prog[i] = $urandom;
        do_session(32'hCAFE_0100, 6, 1'b0, 0);

        // One-word program
        prog[0] = $urandom;
        do_session(32'h0000_0004, 1, 1'b1, 0);

        // Random sessions
        for (int s = 0; s < 10; s++) begin
            bit ul;
            int n;
            for (int i = 0; i < 8; i++) prog[i] = $urandom;
            ul = 1'($urandom_range(0, 1));
            n  = ul ? int'($urandom_range(1, DEPTH)) : int'($urandom_range(DEPTH, 7));
            do_session($urandom, n, ul, int'($urandom_range(0, 2)));
        end

        // Reset mid-LOAD
        for (int i = 0; i < 8; i++) prog[i] = $urandom;
        @(negedge clk);
        load_start = 1'b1;
        boot_pc    = 32'h0BAD_0000;
        @(negedge clk);
        load_start = 1'b0;
        load_valid = 1'b1;
        load_data  = prog[0];
        @(negedge clk);
        check("mid_wr0_addr", imem_addr, 0);
        load_data = prog[1];
        @(negedge clk);
        load_valid = 1'b0;
        check("mid_wr1_we", imem_we, 1);
        check("mid_wr1_addr", imem_addr, 1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_we", imem_we, 0);
        check("mid_rst_cpu_reset", cpu_reset, 1);
        check("mid_rst_goe", cpu_goe, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", load_ready, 0);
        check("mid_rst_count", word_count, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_no_wr", imem_we, 0);
            check("post_rst_halt", cpu_reset, 1);
        end
        for (int i = 0; i < 8; i++) prog[i] = $urandom;
        do_session(32'h0000_0080, 3, 1'b1, 2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_boot_loader.md
# cpu_boot_loader

Boot sequencer that sits in front of the CPU and drives its `reset`, `GOE` and `PCData` inputs. It accepts a program as a stream of 32-bit words over a valid/ready handshake and writes them into instruction memory from word address 0. It holds the CPU in reset while loading, then releases it to run from a latched start address. It replaces bench-driven boot stimulus with a synthesizable controller.

## Interface

Parameters:
- `ADDR_WIDTH`, 8: instruction-memory word-address width; depth = 2^ADDR_WIDTH words.
- `HOLD_CYCLES`, 4: cycles `cpu_reset` stays high with `cpu_goe` high after loading ends; must be ≥1.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `load_start`  in  1  one-cycle request to begin a load session.
- `boot_pc`  in  32  start PC; sampled on an accepted `load_start`.
- `load_valid`  in  1  `load_data` is valid.
- `load_ready`  out  1  loader accepts a word this cycle.
- `load_data`  in  32  instruction word.
- `load_last`  in  1  marks the final word of the session; qualified by the handshake.
- `imem_we`  out  1  instruction-memory write enable.
- `imem_addr`  out  ADDR_WIDTH  instruction-memory word address.
- `imem_wdata`  out  32  instruction-memory write data.
- `cpu_reset`  out  1  drives the CPU `reset` input.
- `cpu_goe`  out  1  drives the CPU `GOE` input.
- `cpu_pcdata`  out  32  drives the CPU `PCData` input.
- `busy`  out  1  high in LOAD or HOLD.
- `word_count`  out  ADDR_WIDTH+1  number of words accepted this session.
- `overflow`  out  1  sticky flag: the session exceeded memory depth.

## Operation

- The FSM has four states: HALT, LOAD, HOLD, RUN.
- **Values under reset:**
  - State is HALT.
  - `cpu_reset` = 1, `cpu_goe` = 0, `cpu_pcdata` = 0.
  - `imem_we` = 0, `imem_addr` = 0, `imem_wdata` = 0.
  - `word_count` = 0, `overflow` = 0, `busy` = 0, `load_ready` = 0.
- **HALT:** `cpu_reset` = 1, `cpu_goe` = 0. `load_start` moves to LOAD.
- **LOAD:** `load_ready` = 1, `cpu_reset` = 1, `cpu_goe` = 0.
  - A word is accepted in any cycle where `load_valid` and `load_ready` are both high.
  - An accepted word is written to address `word_count[ADDR_WIDTH-1:0]`, then `word_count` increments.
  - If the accepted word has `load_last` = 1, go to HOLD.
  - If the accepted word makes `word_count` equal 2^ADDR_WIDTH and `load_last` = 0, set `overflow` and go to HOLD. Memory contents are kept (truncated program).
  - Words offered after this point are not accepted.
- **HOLD:**
  - `cpu_reset` = 1, `cpu_goe` = 1, `cpu_pcdata` = the latched `boot_pc`.
  - A counter runs HOLD_CYCLES cycles, then the FSM goes to RUN.
- **RUN:** `cpu_reset` = 0, `cpu_goe` = 1, `cpu_pcdata` holds its value. `load_start` moves to LOAD.
- **Accepting `load_start`** (in HALT or RUN):
  - `boot_pc` is latched.
  - `word_count` is cleared to 0.
  - `overflow` is cleared.
- `load_start` in LOAD or HOLD is ignored.
- `load_ready` is combinational from state; every other output is registered.

## Timing

- `load_start` sampled at edge N: LOAD is entered, `load_ready` = 1 from cycle N+1, and `cpu_reset` = 1 from cycle N+1. When coming from RUN, the CPU is re-reset one cycle after the request.
- A word accepted at edge N appears at edge N+1 as `imem_we` = 1 with its address and data, for exactly one cycle.
- Back-to-back accepts give one write per cycle.
- The final word accepted at edge N:
  - HOLD entered and `cpu_goe` = 1 at N+1.
  - `cpu_reset` falls at N+1+HOLD_CYCLES.
  - The last `imem_we` (at N+1) therefore always precedes reset release.
- `word_count` updates at the accept edge and is readable the following cycle.
- Reset asserted mid-LOAD or mid-HOLD:
  - Immediately returns to HALT values, independent of `clk`.
  - An in-flight `imem_we` is dropped.
  - Memory contents are not guaranteed.
- `load_valid` with `load_last` = 1 as the first word is a legal one-word program: `word_count` = 1.
- `load_valid` with `load_ready` = 0 has no effect; the source must hold the word.

## Test plan

- **Reset values:** assert `reset` for 3 cycles → all outputs at their reset values. Deassert → stays in HALT with `cpu_reset` = 1 and `cpu_goe` = 0 indefinitely.
- **Three-word load:**
  - Stimulus: `boot_pc` = 0x0000_0040 with `load_start`, then 0x2001_0005, 0x2002_0003, 0x0022_1820 (last) on consecutive cycles.
  - Response: writes at addresses 0, 1, 2 on consecutive cycles; `word_count` = 3.
  - Response: `cpu_reset` falls exactly 4 cycles after HOLD entry; `cpu_pcdata` = 0x40; `overflow` = 0.
- **Handshake stalls:** `load_valid` toggles every other cycle during LOAD → writes occur only on valid cycles, addresses stay contiguous, and no word is duplicated or lost.
- **Overflow:** `ADDR_WIDTH` = 2; send 6 words with no `load_last` → 4 writes (addresses 0–3), `overflow` = 1, HOLD entered, words 5–6 not accepted.
- **Reload from RUN:** `load_start` while running → `cpu_reset` = 1 next cycle, `word_count` = 0, `overflow` cleared, new `boot_pc` appears on `cpu_pcdata` at HOLD.
- **Reset mid-LOAD:** assert `reset` after 2 words → HALT immediately with no further `imem_we`. A following `load_start` restarts from address 0.
